aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL expose parameter NUM_ROUNDS, default 10: number of AES rounds sequenced.
REQ-003 SHALL expose parameter DP_TIMEOUT, default 64: maximum number of cycles to wait for dp_done.
REQ-004 SHALL provide these ports, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin loading a block
- in_valid  in  1  key_byte and state_byte valid this cycle
- key_byte  in  8  serial key byte
- state_byte  in  8  serial plaintext byte
- load  out  1  controller accepting input bytes
- ready  out  1  state_out_byte valid
- state_out_byte  out  8  serial ciphertext byte
- busy  out  1  block in progress
- error  out  1  datapath timeout, sticky
- dp_start  out  1  one-cycle round launch pulse
- dp_round  out  4  round number 1..NUM_ROUNDS (keyNum)
- dp_final  out  1  last round, MixColumns bypassed
- dp_state  out  128  round input state
- dp_key  out  128  previous round key
- dp_done  in  1  round result valid
- dp_state_in  in  128  round output state
- dp_key_in  in  128  new round key

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, ARK0, ISSUE, WAIT, UNLOAD.
REQ-006 IDLE: start=1 -> LOAD; load=1 from the next cycle; byte counter cleared.
REQ-007 LOAD: each cycle with in_valid=1 SHALL capture one byte pair.
- First byte goes into bits [127:120]; byte k goes into [127-8k -: 8].
- After 16 bytes -> ARK0 and load=0.
- in_valid=0 stalls without penalty.
REQ-008 ARK0 SHALL take 1 cycle: dp_state <= state XOR key, dp_key <= key, round counter <= 1, then -> ISSUE.
REQ-009 ISSUE SHALL take 1 cycle.
- Assert dp_start for exactly one cycle.
- Drive dp_round = round counter.
- Drive dp_final = (counter == NUM_ROUNDS).
- Then -> WAIT.
REQ-010 dp_round, dp_final, dp_state and dp_key SHALL remain stable from ISSUE until dp_done is sampled.
REQ-011 WAIT: on dp_done=1, register dp_state_in into dp_state and dp_key_in into dp_key.
- If counter < NUM_ROUNDS: increment the counter -> ISSUE.
- Otherwise -> UNLOAD.
REQ-012 dp_done outside WAIT SHALL be ignored.
REQ-013 WAIT timeout: after DP_TIMEOUT cycles without dp_done, set error=1 and -> IDLE. error clears only on rst.
REQ-014 UNLOAD SHALL emit 16 consecutive cycles of ready=1, MSB byte first (bits [127:120] first), no gaps, then -> IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 start in the same cycle UNLOAD completes SHALL be ignored; it is accepted only from IDLE.
REQ-018 Latency from the 16th accepted byte to the first ready:
- equals 1 + NUM_ROUNDS × (2 + datapath latency) cycles;
- equals 41 cycles for NUM_ROUNDS = 10 with a 2-cycle datapath.
REQ-019 The round counter SHALL be 4 bits, saturate at NUM_ROUNDS and never wrap.
REQ-020 The byte counter SHALL be 5 bits and be reused by LOAD and UNLOAD.

Reset
REQ-021 rst SHALL force, on the next clock edge:
- state IDLE;
- all counters 0;
- load, ready, busy, error, dp_start, dp_final = 0;
- state_out_byte, dp_round, dp_state, dp_key = 0.
REQ-022 rst asserted in any state SHALL abort the block with no further dp_start or ready.

Structure
REQ-023 Package aes_ctrl_pkg SHALL hold:
- the FSM state enumeration;
- BLOCK_BYTES = 16;
- NUM_ROUNDS default = 10.
REQ-024 Byte-serial capture and emission SHALL be one sub-module, aes_byte_serdes (128-bit shift register with load/shift enables). The FSM stays in aes_round_ctrl.

Verification
REQ-025 FIPS-197 C.1 check, with a behavioural round-datapath model of 2-cycle latency:
- stimulus: key 000102…0f, plaintext 00112233…eeff;
- ARK0 SHALL give dp_state 00102030405060708090a0b0c0d0e0f0;
- output SHALL be 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a;
- first ready SHALL occur 41 cycles after the last byte.
REQ-026 Load stall: in_valid deasserted for 3 cycles after byte 7 -> 16 bytes captured correctly, same ciphertext.
REQ-027 Round sequencing: dp_round SHALL step 1..10, with dp_final=1 only on round 10 and exactly 10 dp_start pulses.
REQ-028 Timeout: dp_done never asserted -> error=1 exactly 64 cycles after dp_start, then busy=0.
REQ-029 Reset mid-operation: rst during WAIT of round 5 -> all outputs 0 next cycle, and a following new block encrypts correctly.
REQ-030 Spurious inputs ignored: start pulsed during WAIT, and dp_done pulsed in IDLE -> no state change.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the byte-serial AES round controller.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARK0,
    ST_ISSUE,
    ST_WAIT,
    ST_UNLOAD
  } ctrl_state_e;

  localparam int BLOCK_BYTES        = 16;
  localparam int BLOCK_BITS         = 8 * BLOCK_BYTES;
  localparam int NUM_ROUNDS_DEFAULT = 10;
  localparam int DP_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/aes_byte_serdes.sv
// Byte-serial capture of the key/plaintext block and byte-serial emission of the result.
module aes_byte_serdes
  import aes_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_capture,
  input  logic [7:0]            i_state_byte,
  input  logic [7:0]            i_key_byte,
  input  logic                  i_load,
  input  logic [BLOCK_BITS-1:0] i_load_data,
  input  logic                  i_emit,
  output logic [BLOCK_BITS-1:0] o_state,
  output logic [BLOCK_BITS-1:0] o_key,
  output logic [7:0]            o_byte
);

  logic [BLOCK_BITS-1:0] r_state;
  logic [BLOCK_BITS-1:0] r_key;

  // Bytes enter at the LSB end, so after a full block the first byte sits in the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
    end else if (i_load) begin
      r_state <= i_load_data;
    end else if (i_capture) begin
      r_state <= {r_state[BLOCK_BITS-9:0], i_state_byte};
      r_key   <= {r_key[BLOCK_BITS-9:0], i_key_byte};
    end else if (i_emit) begin
      r_state <= {r_state[BLOCK_BITS-9:0], 8'h00};
    end
  end

  assign o_state = r_state;
  assign o_key   = r_key;
  assign o_byte  = r_state[BLOCK_BITS-1 -: 8];

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: loads a block byte-serially, drives an external round datapath, unloads the result.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int DP_TIMEOUT = DP_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   key_byte,
  input  logic [7:0]   state_byte,
  output logic         load,
  output logic         ready,
  output logic [7:0]   state_out_byte,
  output logic         busy,
  output logic         error,
  output logic         dp_start,
  output logic [3:0]   dp_round,
  output logic         dp_final,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  input  logic         dp_done,
  input  logic [127:0] dp_state_in,
  input  logic [127:0] dp_key_in
);

  localparam int               TMO_W      = $clog2(DP_TIMEOUT + 1);
  localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [4:0]       LAST_BYTE  = 5'(BLOCK_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(DP_TIMEOUT - 1);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next;
  logic [4:0]       r_cnt;
  logic [3:0]       r_round;
  logic [TMO_W-1:0] r_tmo;
  logic             r_error;
  logic [127:0]     r_dp_state;
  logic [127:0]     r_dp_key;

  logic             w_capture;
  logic             w_emit;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_ark;
  logic             w_take;
  logic             w_round_inc;
  logic             w_tmo_clr;
  logic             w_tmo_inc;
  logic             w_timeout;
  logic [127:0]     w_sr_state;
  logic [127:0]     w_sr_key;
  logic [7:0]       w_out_byte;

  // The shift register is reloaded on every accepted round result; only the last one is emitted.
  aes_byte_serdes u_serdes (
    .clk          (clk),
    .rst          (rst),
    .i_capture    (w_capture),
    .i_state_byte (state_byte),
    .i_key_byte   (key_byte),
    .i_load       (w_take),
    .i_load_data  (dp_state_in),
    .i_emit       (w_emit),
    .o_state      (w_sr_state),
    .o_key        (w_sr_key),
    .o_byte       (w_out_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_capture      = 1'b0;
    w_emit         = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_ark          = 1'b0;
    w_take         = 1'b0;
    w_round_inc    = 1'b0;
    w_tmo_clr      = 1'b0;
    w_tmo_inc      = 1'b0;
    w_timeout      = 1'b0;
    load           = (r_state == ST_LOAD);
    ready          = (r_state == ST_UNLOAD);
    busy           = (r_state != ST_IDLE);
    dp_start       = (r_state == ST_ISSUE);
    dp_final       = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (r_round == LAST_ROUND);
    state_out_byte = (r_state == ST_UNLOAD) ? w_out_byte : '0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next    = ST_LOAD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          w_capture = 1'b1;
          if (r_cnt == LAST_BYTE) begin
            w_cnt_clr = 1'b1;
            w_next    = ST_ARK0;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_ARK0: begin
        w_ark  = 1'b1;
        w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_tmo_clr = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (dp_done) begin
          w_take = 1'b1;
          if (r_round < LAST_ROUND) begin
            w_round_inc = 1'b1;
            w_next      = ST_ISSUE;
          end else begin
            w_next = ST_UNLOAD;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      ST_UNLOAD: begin
        w_emit = 1'b1;
        if (r_cnt == LAST_BYTE) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The timeout count includes the ISSUE cycle, so it measures cycles since dp_start rose.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_round    <= '0;
      r_tmo      <= '0;
      r_error    <= 1'b0;
      r_dp_state <= '0;
      r_dp_key   <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 5'd1;

      if (w_ark)            r_round <= 4'd1;
      else if (w_round_inc) r_round <= r_round + 4'd1;

      if (w_tmo_clr)      r_tmo <= TMO_W'(1);
      else if (w_tmo_inc) r_tmo <= r_tmo + TMO_W'(1);

      if (w_timeout) r_error <= 1'b1;

      if (w_ark) begin
        r_dp_state <= w_sr_state ^ w_sr_key;
        r_dp_key   <= w_sr_key;
      end else if (w_take) begin
        r_dp_state <= dp_state_in;
        r_dp_key   <= dp_key_in;
      end
    end
  end

  assign dp_round = r_round;
  assign dp_state = r_dp_state;
  assign dp_key   = r_dp_key;
  assign error    = r_error;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural 2-cycle AES round datapath plus a byte scoreboard.
module tb_aes_round_ctrl;

  localparam int NR  = 10;
  localparam int TMO = 64;
  localparam int NV  = 4;

  typedef logic [263:0] cw_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ark;
    logic [127:0] ct;
    int           stall_at;
    int           stall_len;
    bit           spur;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [7:0]   key_byte;
  logic [7:0]   state_byte;
  logic         load;
  logic         ready;
  logic [7:0]   state_out_byte;
  logic         busy;
  logic         error;
  logic         dp_start;
  logic [3:0]   dp_round;
  logic         dp_final;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_done;
  logic [127:0] dp_state_in;
  logic [127:0] dp_key_in;

  logic         m_done;
  logic [127:0] m_state;
  logic [127:0] m_key;
  logic         m_en;
  logic         spur_done;

  int           checks;
  int           errors;
  logic [7:0]   exp_q[$];
  logic [3:0]   log_round[$];
  bit           log_final[$];
  logic [7:0]   sbox[256];
  vec_t         vecs[NV];

  assign dp_done     = m_done | spur_done;
  assign dp_state_in = spur_done ? 128'hdeadbeef_cafef00d_01234567_89abcdef : m_state;
  assign dp_key_in   = spur_done ? ~m_key : m_key;

  aes_round_ctrl #(.NUM_ROUNDS(NR), .DP_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .key_byte       (key_byte),
    .state_byte     (state_byte),
    .load           (load),
    .ready          (ready),
    .state_out_byte (state_out_byte),
    .busy           (busy),
    .error          (error),
    .dp_start       (dp_start),
    .dp_round       (dp_round),
    .dp_final       (dp_final),
    .dp_state       (dp_state),
    .dp_key         (dp_key),
    .dp_done        (dp_done),
    .dp_state_in    (dp_state_in),
    .dp_key_in      (dp_key_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(a));
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 1; i < r; i++) x = xt(x);
    return x;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon(int'(r)), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input bit fin);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) a[k] = sbox[s[127-8*k -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
        b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
      end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[k];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= NR; r++) begin
      k = next_key(k, 4'(r));
      s = aes_round(s, k, r == NR);
    end
    return s;
  endfunction

  task automatic check(input string name, input cw_t act, input cw_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round datapath: result and dp_done appear three falling edges after dp_start is seen.
  task automatic model_loop();
    int           cnt;
    logic [127:0] ns, nk, ls, lk;
    logic [3:0]   lr;
    logic         lf;
    cnt = 0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          check("dp_hold", cw_t'({dp_final, dp_round, dp_key, dp_state}), cw_t'({lf, lr, lk, ls}));
          cnt--;
          if (cnt == 0) begin
            m_done  = 1'b1;
            m_state = ns;
            m_key   = nk;
          end
        end
        if (dp_start) begin
          log_round.push_back(dp_round);
          log_final.push_back(dp_final);
          ls = dp_state; lk = dp_key; lr = dp_round; lf = dp_final;
          nk = next_key(dp_key, dp_round);
          ns = aes_round(dp_state, nk, dp_final);
          if (m_en) cnt = 3;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=%0h required=no_output", state_out_byte);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", cw_t'(state_out_byte), cw_t'(e));
        end
      end
    end
  endtask

  task automatic load_block(input vec_t v, input bit push);
    log_round.delete();
    log_final.delete();
    if (push)
      for (int k = 0; k < 16; k++) exp_q.push_back(v.ct[127-8*k -: 8]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_asserted", cw_t'(load), cw_t'(1));
    for (int k = 0; k < 16; k++) begin
      if (k == v.stall_at) begin
        in_valid = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          key_byte   = 8'($urandom);
          state_byte = 8'($urandom);
          tick();
        end
      end
      in_valid   = 1'b1;
      key_byte   = v.key[127-8*k -: 8];
      state_byte = v.pt[127-8*k -: 8];
      tick();
    end
    in_valid = 1'b0;
    check("load_dropped", cw_t'(load), cw_t'(0));
  endtask

  task automatic run_block(input vec_t v);
    int lat;
    int n;
    load_block(v, 1'b1);
    tick();
    check("ark0_state", cw_t'(dp_state), cw_t'(v.ark));
    check("first_issue", cw_t'({dp_start, dp_round}), cw_t'({1'b1, 4'd1}));
    lat = 1;
    while (!ready && lat < 200) begin
      if (v.spur && lat == 10) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
    end
    check("latency", cw_t'(lat), cw_t'(41));
    n = 0;
    while (ready && n < 40) begin
      if (v.spur && n == 15) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check("ready_run", cw_t'(n), cw_t'(16));
    check("idle_after", cw_t'({busy, load}), cw_t'(0));
    check("queue_empty", cw_t'(exp_q.size()), cw_t'(0));
    check("n_starts", cw_t'(log_round.size()), cw_t'(NR));
    for (int i = 0; i < NR && i < log_round.size(); i++)
      check("round_seq", cw_t'({log_round[i], log_final[i]}), cw_t'({4'(i + 1), i == NR - 1}));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; key_byte = '0; state_byte = '0;
    spur_done = 1'b0; m_en = 1'b1; m_done = 1'b0; m_state = '0; m_key = '0;
    build_sbox();

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ark: 128'h00102030405060708090a0b0c0d0e0f0, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                stall_at: 16, stall_len: 0, spur: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].stall_at  = 8;
    vecs[1].stall_len = 3;
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ark: 128'h193de3bea0f4e22b9ac68d2ae9f84808, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                stall_at: 16, stall_len: 0, spur: 1'b1};
    vecs[3].key       = {$urandom, $urandom, $urandom, $urandom};
    vecs[3].pt        = {$urandom, $urandom, $urandom, $urandom};
    vecs[3].ark       = vecs[3].key ^ vecs[3].pt;
    vecs[3].ct        = aes_ref(vecs[3].key, vecs[3].pt);
    vecs[3].stall_at  = $urandom_range(1, 15);
    vecs[3].stall_len = $urandom_range(1, 4);
    vecs[3].spur      = 1'b0;

    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) tick();
    check("reset_ctrl", cw_t'({load, ready, busy, error, dp_start, dp_final, state_out_byte, dp_round}), cw_t'(0));
    check("reset_data", cw_t'({dp_state, dp_key}), cw_t'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_block(vecs[i]);

    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check("spur_done_state", cw_t'(dp_state), cw_t'(vecs[NV-1].ct));
    check("spur_done_idle", cw_t'({busy, dp_start, load}), cw_t'(0));

    m_en = 1'b0;
    load_block(vecs[0], 1'b0);
    n = 0;
    while (!dp_start && n < 10) begin tick(); n++; end
    check("tmo_issue", cw_t'(dp_start), cw_t'(1));
    n = 0;
    while (!error && n < 200) begin tick(); n++; end
    check("tmo_latency", cw_t'(n), cw_t'(TMO));
    check("tmo_idle", cw_t'({busy, error}), cw_t'(2'b01));
    repeat (5) tick();
    check("error_sticky", cw_t'(error), cw_t'(1));
    m_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("error_cleared", cw_t'(error), cw_t'(0));

    load_block(vecs[1], 1'b0);
    n = 0;
    while (!(dp_start && dp_round == 4'd5) && n < 100) begin tick(); n++; end
    check("r5_issue", cw_t'({dp_start, dp_round}), cw_t'({1'b1, 4'd5}));
    tick();
    tick();
    check("r5_wait", cw_t'({busy, dp_start, dp_round}), cw_t'({1'b1, 1'b0, 4'd5}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ctrl", cw_t'({load, ready, busy, error, dp_start, dp_final, state_out_byte, dp_round}), cw_t'(0));
    check("rst_data", cw_t'({dp_state, dp_key}), cw_t'(0));
    repeat (10) tick();
    check("rst_no_restart", cw_t'(log_round.size()), cw_t'(5));
    check("rst_idle", cw_t'(busy), cw_t'(0));
    run_block(vecs[3]);
    run_block(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
